// File: rtl/eth_txarb_rr.sv
// N-channel whole-packet arbiter merging FWFT FIFOs into one tagged TX write stream.
// Define ETH_TXARB_STRICT_PRIO_EN for fixed priority (channel 0 highest); default is round-robin.
module eth_txarb_rr #(
    parameter int NCH       = 4,
    parameter int DW        = 74,
    parameter int TLAST_BIT = 1,
    parameter int TAGW      = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NCH*DW-1:0]   fifo_dout,
    input  logic [NCH-1:0]      fifo_empty,
    output logic [NCH-1:0]      fifo_rd_en,
    output logic [TAGW+DW-1:0]  din,
    input  logic                full,
    output logic                wr_en
);
    localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t         state, next_state;
    logic [GW-1:0]  grant;
    logic [GW-1:0]  pick;
    logic           any_req;
    logic           pop;
    logic           cur_empty;
    logic [DW-1:0]  cur_word;

`ifndef ETH_TXARB_STRICT_PRIO_EN
    logic [GW-1:0]  last_grant;
`endif

    // Candidate grant for the next packet, evaluated while idle
    always_comb begin : pick_blk
`ifdef ETH_TXARB_STRICT_PRIO_EN
        pick    = '0;
        any_req = (fifo_empty != {NCH{1'b1}});
        for (int i = NCH - 1; i >= 0; i--) begin
            if (!fifo_empty[i]) pick = GW'(i);
        end
`else
        int            idx;
        logic          found;
        logic [GW-1:0] cand;
        pick    = '0;
        any_req = (fifo_empty != {NCH{1'b1}});
        found   = 1'b0;
        idx     = 0;
        cand    = '0;
        for (int i = 1; i <= NCH; i++) begin
            idx = int'(last_grant) + i;
            if (idx >= NCH) idx = idx - NCH;
            cand = GW'(idx);
            if (!found && !fifo_empty[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
`endif
    end

    // Mux the granted channel; the pop is combinational so full stalls within the cycle
    always_comb begin
        cur_empty  = 1'b1;
        cur_word   = '0;
        fifo_rd_en = '0;
        for (int c = 0; c < NCH; c++) begin
            if (grant == GW'(c)) begin
                cur_empty = fifo_empty[c];
                cur_word  = fifo_dout[c*DW +: DW];
            end
        end
        pop = (state == SEND) && !cur_empty && !full;
        for (int c = 0; c < NCH; c++) begin
            fifo_rd_en[c] = pop && (grant == GW'(c));
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (any_req && !full) next_state = SEND;
            SEND:    if (pop && cur_word[TLAST_BIT]) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
`ifndef ETH_TXARB_STRICT_PRIO_EN
            last_grant <= GW'(NCH - 1);
`endif
            wr_en <= 1'b0;
            din   <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && next_state == SEND) begin
                grant <= pick;
`ifndef ETH_TXARB_STRICT_PRIO_EN
                last_grant <= pick;
`endif
            end
            wr_en <= pop;
            if (pop) din <= {TAGW'(grant), cur_word};
        end
    end

endmodule
